// File: rtl/ssm_fetch_sched.sv
// ssm_fetch_sched: single-port bitstream fetch scheduler feeding four substream prefetch FIFOs.
// Define SSM_FETCH_PERF_EN to build the saturating read counter on o_perf_rd_cnt.
module ssm_fetch_sched #(
   parameter int DATA_W     = 128,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int INIT_WORDS = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                i_start,
   input  logic [ADDR_W-1:0]   i_base_addr,
   output logic                o_mem_rd_en,
   output logic [ADDR_W-1:0]   o_mem_rd_addr,
   input  logic [DATA_W-1:0]   i_mem_rd_data,
   input  logic [3:0]          i_ssm_rd_en,
   output logic [3:0]          o_ssm_valid,
   output logic [4*DATA_W-1:0] o_ssm_data,
   output logic                o_ready,
   output logic                o_busy,
   output logic [3:0]          o_underflow_err,
   output logic [31:0]         o_perf_rd_cnt
);
   localparam int FA = $clog2(FIFO_DEPTH);
   localparam int QA = $clog2(4*FIFO_DEPTH);
   localparam int NI = 4*INIT_WORDS;
   localparam int CW = $clog2(NI+1);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAIN, S_RUN} state_t;
   state_t r_state, w_state_nx;

   logic [CW-1:0]     r_cnt;
   logic [ADDR_W-1:0] r_rd_ptr, r_mem_rd_addr;
   logic              r_mem_rd_en, r_land_vld;
   logic [1:0]        r_pend_ssm, r_land_ssm;
   logic [1:0]        r_q [4*FIFO_DEPTH];
   logic [QA:0]       r_qwp, r_qrp;
   logic [3:0]        r_uf;
   logic              w_start, w_issue;
   logic [1:0]        w_issue_ssm;
   logic [3:0]        w_valid, w_pop;
   logic [QA-1:0]     w_qidx [4];

   assign w_start = i_start && (r_state == S_IDLE || r_state == S_RUN);
   assign w_pop   = i_ssm_rd_en & w_valid;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nx;

   always_comb begin
      w_state_nx  = r_state;
      w_issue     = 1'b0;
      w_issue_ssm = 2'd0;
      case (r_state)
         S_IDLE:  w_state_nx = w_start ? S_INIT : S_IDLE;
         S_INIT: begin
            w_issue     = r_cnt < CW'(NI);
            w_issue_ssm = r_cnt[1:0];
            w_state_nx  = (r_cnt == CW'(NI)) ? S_DRAIN : S_INIT;
         end
         S_DRAIN: w_state_nx = S_RUN;
         default: begin
            w_issue     = !w_start && (r_qwp != r_qrp);
            w_issue_ssm = r_q[r_qrp[QA-1:0]];
            w_state_nx  = w_start ? S_INIT : S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_cnt         <= '0;
         r_rd_ptr      <= '0;
         r_mem_rd_en   <= 1'b0;
         r_mem_rd_addr <= '0;
         r_pend_ssm    <= '0;
         r_land_vld    <= 1'b0;
         r_land_ssm    <= '0;
         r_uf          <= '0;
      end else begin
         r_mem_rd_en <= w_issue;
         // data of a read already on the bus when restarting belongs to the old slice
         r_land_vld  <= r_mem_rd_en && !w_start;
         r_land_ssm  <= r_pend_ssm;
         r_uf        <= w_start ? 4'd0 : r_uf | ((r_state == S_RUN) ? i_ssm_rd_en & ~w_valid : 4'd0);
         if (w_issue) begin
            r_mem_rd_addr <= r_rd_ptr;
            r_rd_ptr      <= r_rd_ptr + ADDR_W'(1);
            r_pend_ssm    <= w_issue_ssm;
         end
         if (w_start) begin
            r_rd_ptr <= i_base_addr;
            r_cnt    <= '0;
         end else if (r_state == S_INIT) r_cnt <= r_cnt + CW'(1);
      end

   // simultaneous pops land in consecutive queue slots, lowest index first
   always_comb
      for (int k = 0; k < 4; k++) begin
         w_qidx[k] = r_qwp[QA-1:0];
         for (int j = 0; j < k; j++) w_qidx[k] = w_qidx[k] + QA'(w_pop[j]);
      end

   always_ff @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (w_pop[k]) r_q[w_qidx[k]] <= 2'(k);

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_qwp <= '0;
         r_qrp <= '0;
      end else if (w_start) begin
         r_qwp <= '0;
         r_qrp <= '0;
      end else begin
         r_qwp <= r_qwp + (QA+1)'($countones(w_pop));
         if (w_issue && r_state == S_RUN) r_qrp <= r_qrp + (QA+1)'(1);
      end

   for (genvar g = 0; g < 4; g++) begin : g_fifo
      logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
      logic [FA:0]       r_wp, r_rp;
      logic              w_wr;
      assign w_wr       = r_land_vld && (r_land_ssm == 2'(g));
      assign w_valid[g] = (r_state == S_RUN) && (r_wp != r_rp);
      assign o_ssm_data[g*DATA_W +: DATA_W] = w_valid[g] ? r_mem[r_rp[FA-1:0]] : '0;
      always_ff @(posedge clk)
         if (w_wr) r_mem[r_wp[FA-1:0]] <= i_mem_rd_data;
      always_ff @(posedge clk or negedge rstn)
         if (!rstn) begin
            r_wp <= '0;
            r_rp <= '0;
         end else if (w_start) begin
            r_wp <= '0;
            r_rp <= '0;
         end else begin
            if (w_wr)     r_wp <= r_wp + (FA+1)'(1);
            if (w_pop[g]) r_rp <= r_rp + (FA+1)'(1);
         end
   end

`ifdef SSM_FETCH_PERF_EN
   logic [31:0] r_perf;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn)                            r_perf <= '0;
      else if (w_start)                     r_perf <= '0;
      else if (r_mem_rd_en && r_perf != '1) r_perf <= r_perf + 32'd1;
   assign o_perf_rd_cnt = r_perf;
`else
   assign o_perf_rd_cnt = '0;
`endif

   assign o_mem_rd_en     = r_mem_rd_en;
   assign o_mem_rd_addr   = r_mem_rd_addr;
   assign o_ssm_valid     = w_valid;
   assign o_ready         = r_state == S_RUN;
   assign o_busy          = r_state == S_INIT || r_state == S_DRAIN;
   assign o_underflow_err = r_uf;
endmodule

// File: tb/tb_ssm_fetch_sched.sv
// tb_ssm_fetch_sched: directed scoreboard bench; expected reads and FIFO words are queued when stimulus is driven.
module tb_ssm_fetch_sched;
   localparam int DW = 128;
   localparam int AW = 8;

   typedef struct packed {logic [AW-1:0] addr; int ssm; int due;} rd_t;
   typedef struct packed {logic [DW-1:0] word; int vis;} wd_t;

   logic            clk = 1'b0, rstn = 1'b0, start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic            mem_rd_en;
   logic [AW-1:0]   mem_rd_addr;
   logic [DW-1:0]   mem_rd_data = '0;
   logic [3:0]      ssm_rd_en = '0, ssm_valid, underflow_err;
   logic [4*DW-1:0] ssm_data;
   logic            ready, busy;
   logic [31:0]     perf_rd_cnt;

   int n_chk = 0, n_pass = 0, cyc = 0;
   int bsy_from = 0, rdy_from = 0, last_due = 0, exp_perf = 0;
   bit started = 1'b0;
   logic [AW-1:0] exp_ptr = '0;
   logic [3:0] exp_uf = '0;
   rd_t rdq[$];
   wd_t dq[4][$];

   ssm_fetch_sched dut (
      .clk(clk), .rstn(rstn), .i_start(start), .i_base_addr(base_addr),
      .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data),
      .i_ssm_rd_en(ssm_rd_en), .o_ssm_valid(ssm_valid), .o_ssm_data(ssm_data),
      .o_ready(ready), .o_busy(busy), .o_underflow_err(underflow_err), .o_perf_rd_cnt(perf_rd_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word(logic [AW-1:0] a);
      return {8'hC3, 112'd0, a};
   endfunction

   // buffer model: data only in the cycle after the strobe, junk otherwise
   always @(posedge clk) mem_rd_data <= mem_rd_en ? word(mem_rd_addr) : '1;

   function automatic bit running();
      return started && cyc >= rdy_from;
   endfunction

   function automatic bit ev(int k);
      return running() && dq[k].size() > 0 && dq[k][0].vis <= cyc;
   endfunction

   function automatic int perf_exp();
`ifdef SSM_FETCH_PERF_EN
      return exp_perf;
`else
      return 0;
`endif
   endfunction

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
   endtask

   task automatic tick();
      rd_t r;
      wd_t w;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("ready", DW'(ready), DW'(running()));
      chk("busy", DW'(busy), DW'(started && cyc >= bsy_from && cyc < rdy_from));
      chk("underflow", DW'(underflow_err), DW'(exp_uf));
      chk("perf", DW'(perf_rd_cnt), DW'(perf_exp()));
      if (mem_rd_en) begin
         exp_perf++;
         if (rdq.size() == 0) chk("extra_rd", DW'(mem_rd_en), DW'(1'b0));
         else begin
            r = rdq.pop_front();
            chk("rd_addr", DW'(mem_rd_addr), DW'(r.addr));
            chk("rd_cycle", DW'(cyc), DW'(r.due));
            w = '{word(r.addr), cyc + 2};
            dq[r.ssm].push_back(w);
         end
      end else if (rdq.size() != 0 && rdq[0].due == cyc) chk("missed_rd", DW'(mem_rd_en), DW'(1'b1));
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("valid%0d", k), DW'(ssm_valid[k]), DW'(ev(k)));
         if (ev(k)) chk($sformatf("data%0d", k), ssm_data[k*DW +: DW], dq[k][0].word);
      end
   endtask

   task automatic do_pops(logic [3:0] m);
      rd_t r;
      for (int k = 0; k < 4; k++)
         if (m[k] && ev(k)) begin
            dq[k].delete(0);
            last_due = (cyc + 2 > last_due + 1) ? cyc + 2 : last_due + 1;
            r = '{exp_ptr, k, last_due};
            rdq.push_back(r);
            exp_ptr++;
         end else if (m[k] && running()) exp_uf[k] = 1'b1;
      ssm_rd_en = m;
      tick();
      ssm_rd_en = '0;
   endtask

   task automatic do_start(logic [AW-1:0] b);
      rd_t r;
      start = 1'b1;
      base_addr = b;
      rdq.delete();
      for (int k = 0; k < 4; k++) dq[k].delete();
      exp_uf = '0;
      exp_perf = 0;
      started = 1'b1;
      bsy_from = cyc + 1;
      rdy_from = cyc + 11;
      for (int i = 0; i < 8; i++) begin
         r = '{b + AW'(i), i % 4, cyc + 2 + i};
         rdq.push_back(r);
      end
      exp_ptr = b + AW'(8);
      last_due = cyc + 9;
      tick();
      start = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_rd_en", DW'(mem_rd_en), DW'(1'b0));
      chk("rst_rd_addr", DW'(mem_rd_addr), DW'(0));
      chk("rst_valid", DW'(ssm_valid), DW'(0));
      for (int k = 0; k < 4; k++) chk($sformatf("rst_data%0d", k), ssm_data[k*DW +: DW], DW'(0));
      chk("rst_ready", DW'(ready), DW'(1'b0));
      chk("rst_busy", DW'(busy), DW'(1'b0));
      chk("rst_uf", DW'(underflow_err), DW'(0));
      chk("rst_perf", DW'(perf_rd_cnt), DW'(0));
      rstn = 1'b1;
      repeat (2) tick();
      // initial fill from address 0, ready ten cycles after the start edge
      do_start(8'h00);
      repeat (10) tick();
      chk("ready_at_t10", DW'(ready), DW'(1'b1));
      do_pops(4'b0100);
      chk("ssm2_word6", ssm_data[2*DW +: DW], word(8'd6));
      do_pops(4'b0001);
      repeat (5) tick();
      do_pops(4'b1111);
      repeat (6) tick();
      chk("no_underflow", DW'(underflow_err), DW'(0));
      // drain ssm1 faster than refills arrive
      repeat (5) do_pops(4'b0010);
      repeat (8) tick();
      chk("uf_ssm1", DW'(underflow_err), DW'(4'b0010));
      chk("rd_drained", DW'(rdq.size()), DW'(0));
      // restart with reads in flight, base near the top of the address space
      do_pops(4'b1111);
      do_start(8'hFE);
      chk("uf_cleared", DW'(underflow_err), DW'(0));
      repeat (10) tick();
      chk("perf_at_ready", DW'(perf_rd_cnt), DW'(perf_exp()));
      do_pops(4'b1111);
      do_pops(4'b1111);
      repeat (6) tick();
      do_pops(4'b0110);
      rstn = 1'b0;
      #1;
      chk("arst_ready", DW'(ready), DW'(1'b0));
      chk("arst_valid", DW'(ssm_valid), DW'(0));
      chk("arst_rd_en", DW'(mem_rd_en), DW'(1'b0));
      chk("arst_busy", DW'(busy), DW'(1'b0));
      started = 1'b0;
      rdq.delete();
      for (int k = 0; k < 4; k++) dq[k].delete();
      exp_uf = '0;
      exp_perf = 0;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
      do_start(8'h40);
      repeat (10) tick();
      do_pops(4'b1001);
      repeat (6) tick();
      chk("final_drained", DW'(rdq.size()), DW'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
